// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Elastic pipeline stage that sits between two core stages (F/D, D/E, E/M,
//   M/W). It carries the datapath payload, the control bundle and the hazard
//   source addresses under a valid/ready handshake, in strict FIFO order.
//   With SKID=1 a 2-entry skid buffer makes in_ready_o a register, so there is
//   no combinational path from out_ready_i to in_ready_o. With SKID=0 the
//   stage is a single register and in_ready_o is combinational.
//   A flush kills every held beat and any beat arriving in the same cycle, and
//   zeroes control/source fields so a killed slot can never write state.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           synchronous, active-high
//   flush_i         synchronous kill of held and incoming beats
//   in_valid_i      upstream beat valid
//   in_ready_o      stage can accept a beat
//   in_data_i       upstream payload (DATA_W)
//   in_ctrl_i       upstream control bundle (CTRL_W, all-zero = NOP)
//   in_src_i        upstream source addresses (NUM_SRC*ADDR_W, src0 in LSBs)
//   out_valid_o     downstream beat valid
//   out_ready_i     downstream accepts the beat
//   out_data_o      head payload
//   out_ctrl_o      head control, 0 whenever out_valid_o=0
//   out_src_o       head source addresses, 0 whenever out_valid_o=0
//   occupancy_o     number of beats held (0..2, at most 1 with SKID=0)
//   stall_cycles_o  saturating count of out_valid_o & !out_ready_i cycles

module pipe_stage_skid #(
    parameter int DATA_W   = 160,
    parameter int CTRL_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int SKID     = 1,
    parameter int CLR_DATA = 0,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DATA_W-1:0]         in_data_i,
    input  logic [CTRL_W-1:0]         in_ctrl_i,
    input  logic [NUM_SRC*ADDR_W-1:0] in_src_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_W-1:0]         out_data_o,
    output logic [CTRL_W-1:0]         out_ctrl_o,
    output logic [NUM_SRC*ADDR_W-1:0] out_src_o,
    output logic [1:0]                occupancy_o,
    output logic [CNT_W-1:0]          stall_cycles_o
);

    localparam int SRC_W = NUM_SRC * ADDR_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // EMPTY: nothing held; ONE: main slot valid; TWO: main and skid valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mainData_q, mainData_d, skidData_q, skidData_d;
    logic [CTRL_W-1:0]   mainCtrl_q, mainCtrl_d, skidCtrl_q, skidCtrl_d;
    logic [SRC_W-1:0]    mainSrc_q, mainSrc_d, skidSrc_q, skidSrc_d;
    logic [CNT_W-1:0]    stallCnt_q;
    logic                outValid;
    logic                inReady;
    logic                accept;
    logic                issue;

    assign outValid = (state_q != EMPTY);
    assign issue    = outValid & out_ready_i;
    // A beat offered in a flush cycle is dropped even when in_ready_o is high
    assign accept   = in_valid_i & inReady & ~flush_i;

    generate
        if (SKID != 0) begin : g_skid
            logic inReady_q;

            // Ready is precomputed from the next state, so it only drops once
            // both slots will be occupied after this edge.
            always_ff @(posedge clk) begin
                if (reset) begin
                    inReady_q <= 1'b1;
                end else begin
                    inReady_q <= (state_d != TWO);
                end
            end

            assign inReady = inReady_q;
        end else begin : g_noskid
            // Single register: a new beat fits when the slot is empty or is
            // being drained this cycle. Because of this, TWO is unreachable.
            assign inReady = ~outValid | out_ready_i;
        end
    endgenerate

    // Next-state and slot updates. Flush overrides every handshake; the
    // payload is only cleared when CLR_DATA asks for it, to save toggling.
    always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        mainCtrl_d = mainCtrl_q;
        mainSrc_d  = mainSrc_q;
        skidData_d = skidData_q;
        skidCtrl_d = skidCtrl_q;
        skidSrc_d  = skidSrc_q;

        if (flush_i) begin
            state_d    = EMPTY;
            mainCtrl_d = '0;
            mainSrc_d  = '0;
            skidCtrl_d = '0;
            skidSrc_d  = '0;
            if (CLR_DATA != 0) begin
                mainData_d = '0;
                skidData_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d    = ONE;
                        mainData_d = in_data_i;
                        mainCtrl_d = in_ctrl_i;
                        mainSrc_d  = in_src_i;
                    end
                end
                ONE: begin
                    if (accept && issue) begin
                        mainData_d = in_data_i;
                        mainCtrl_d = in_ctrl_i;
                        mainSrc_d  = in_src_i;
                    end else if (accept) begin
                        state_d    = TWO;
                        skidData_d = in_data_i;
                        skidCtrl_d = in_ctrl_i;
                        skidSrc_d  = in_src_i;
                    end else if (issue) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (issue) begin
                        state_d    = ONE;
                        mainData_d = skidData_q;
                        mainCtrl_d = skidCtrl_q;
                        mainSrc_d  = skidSrc_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and slot registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            mainData_q <= '0;
            mainCtrl_q <= '0;
            mainSrc_q  <= '0;
            skidData_q <= '0;
            skidCtrl_q <= '0;
            skidSrc_q  <= '0;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            mainCtrl_q <= mainCtrl_d;
            mainSrc_q  <= mainSrc_d;
            skidData_q <= skidData_d;
            skidCtrl_q <= skidCtrl_d;
            skidSrc_q  <= skidSrc_d;
        end
    end

    // Backpressure counter: only reset clears it, a flush leaves it alone
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt_q <= '0;
        end else if (outValid && !out_ready_i && (stallCnt_q != CNT_MAX)) begin
            stallCnt_q <= stallCnt_q + CNT_ONE;
        end
    end

    assign in_ready_o     = inReady;
    assign out_valid_o    = outValid;
    assign out_data_o     = mainData_q;
    assign out_ctrl_o     = outValid ? mainCtrl_q : '0;
    assign out_src_o      = outValid ? mainSrc_q : '0;
    assign occupancy_o    = {state_q == TWO, state_q == ONE};
    assign stall_cycles_o = stallCnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
//   Drives two instances of pipe_stage_skid side by side:
//     dut0: SKID=1, CLR_DATA=0, CNT_W=16
//     dut1: SKID=0, CLR_DATA=1, CNT_W=3
//   Directed scenarios cover latency, skid fill/drain, flush and counter
//   saturation; a randomized phase compares both instances against a
//   queue-based reference model of a bounded FIFO stage.

module tb_pipe_stage_skid;

    localparam int DW = 160;
    localparam int CW = 16;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int SW = AW * NS;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
        logic [SW-1:0] src;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush    [2];
    logic          inValid  [2];
    logic          inReady  [2];
    logic [DW-1:0] inData   [2];
    logic [CW-1:0] inCtrl   [2];
    logic [SW-1:0] inSrc    [2];
    logic          outValid [2];
    logic          outReady [2];
    logic [DW-1:0] outData  [2];
    logic [CW-1:0] outCtrl  [2];
    logic [SW-1:0] outSrc   [2];
    logic [1:0]    occ      [2];
    logic [15:0]   stall0;
    logic [2:0]    stall1;

    int checks = 0;
    int errors = 0;

    // Reference model: one bounded queue per instance plus a stall count
    beat_t q0[$];
    beat_t q1[$];
    int    mStall [2];

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W(DW), .CTRL_W(CW), .ADDR_W(AW), .NUM_SRC(NS),
        .SKID(1), .CLR_DATA(0), .CNT_W(16)
    ) dut0 (
        .clk(clk), .reset(reset), .flush_i(flush[0]),
        .in_valid_i(inValid[0]), .in_ready_o(inReady[0]),
        .in_data_i(inData[0]), .in_ctrl_i(inCtrl[0]), .in_src_i(inSrc[0]),
        .out_valid_o(outValid[0]), .out_ready_i(outReady[0]),
        .out_data_o(outData[0]), .out_ctrl_o(outCtrl[0]), .out_src_o(outSrc[0]),
        .occupancy_o(occ[0]), .stall_cycles_o(stall0)
    );

    pipe_stage_skid #(
        .DATA_W(DW), .CTRL_W(CW), .ADDR_W(AW), .NUM_SRC(NS),
        .SKID(0), .CLR_DATA(1), .CNT_W(3)
    ) dut1 (
        .clk(clk), .reset(reset), .flush_i(flush[1]),
        .in_valid_i(inValid[1]), .in_ready_o(inReady[1]),
        .in_data_i(inData[1]), .in_ctrl_i(inCtrl[1]), .in_src_i(inSrc[1]),
        .out_valid_o(outValid[1]), .out_ready_i(outReady[1]),
        .out_data_o(outData[1]), .out_ctrl_o(outCtrl[1]), .out_src_o(outSrc[1]),
        .occupancy_o(occ[1]), .stall_cycles_o(stall1)
    );

    function automatic int qSize(int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t qHead(int s);
        if (s == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic qPush(int s, beat_t b);
        if (s == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    task automatic qPop(int s);
        if (s == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    function automatic int stallMax(int s);
        return (s == 0) ? 65535 : 7;
    endfunction

    function automatic logic [15:0] getStall(int s);
        return (s == 0) ? stall0 : {13'b0, stall1};
    endfunction

    function automatic beat_t randBeat();
        beat_t b;
        b.data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        b.ctrl = CW'($urandom());
        b.src  = SW'($urandom());
        return b;
    endfunction

    task automatic setIn(int s, logic v, beat_t b);
        inValid[s] = v;
        inData[s]  = b.data;
        inCtrl[s]  = b.ctrl;
        inSrc[s]   = b.src;
    endtask

    task automatic idleAll();
        for (int s = 0; s < 2; s++) begin
            flush[s]    = 1'b0;
            outReady[s] = 1'b1;
            setIn(s, 1'b0, '0);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        idleAll();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q0.delete();
        q1.delete();
        mStall[0] = 0;
        mStall[1] = 0;
    endtask

    // Beats offered during reset are dropped; all outputs come up idle
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            setIn(s, 1'b1, randBeat());
            outReady[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idleAll();
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++; if (outValid[s] !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid%0d: got %b expected 0", s, outValid[s]); end
            checks++; if (occ[s] !== 2'd0) begin errors++; $display("[TB] FAIL reset_occ%0d: got %0d expected 0", s, occ[s]); end
            checks++; if (inReady[s] !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready%0d: got %b expected 1", s, inReady[s]); end
            checks++; if (outCtrl[s] !== '0) begin errors++; $display("[TB] FAIL reset_ctrl%0d: got %0h expected 0", s, outCtrl[s]); end
            checks++; if (outSrc[s] !== '0) begin errors++; $display("[TB] FAIL reset_src%0d: got %0h expected 0", s, outSrc[s]); end
            checks++; if (outData[s] !== '0) begin errors++; $display("[TB] FAIL reset_data%0d: got %0h expected 0", s, outData[s]); end
            checks++; if (getStall(s) !== 16'd0) begin errors++; $display("[TB] FAIL reset_stall%0d: got %0d expected 0", s, getStall(s)); end
        end
    endtask

    // Beats 1,2,3 stream through with one cycle of latency
    task automatic test_back_to_back();
        beat_t b;
        doReset();
        outReady[0] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            b.data = DW'(i); b.ctrl = CW'(i); b.src = SW'(i);
            setIn(0, 1'b1, b);
            @(negedge clk);
            checks++; if (outValid[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid%0d: got %b expected 1", i, outValid[0]); end
            checks++; if (outData[0] !== DW'(i)) begin errors++; $display("[TB] FAIL b2b_data%0d: got %0h expected %0h", i, outData[0], i); end
            checks++; if (outCtrl[0] !== CW'(i)) begin errors++; $display("[TB] FAIL b2b_ctrl%0d: got %0h expected %0h", i, outCtrl[0], i); end
            checks++; if (occ[0] !== 2'd1) begin errors++; $display("[TB] FAIL b2b_occ%0d: got %0d expected 1", i, occ[0]); end
            checks++; if (inReady[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready%0d: got %b expected 1", i, inReady[0]); end
        end
        setIn(0, 1'b0, '0);
        @(negedge clk);
        checks++; if (outValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b expected 0", outValid[0]); end
    endtask

    // Fill both slots under backpressure, then drain in order
    task automatic test_skid_full();
        beat_t a, b, c;
        a = '{data: DW'(160'hA), ctrl: 16'hAAAA, src: 10'h0AA};
        b = '{data: DW'(160'hB), ctrl: 16'hBBBB, src: 10'h0BB};
        c = '{data: DW'(160'hC), ctrl: 16'hCCCC, src: 10'h0CC};
        doReset();
        outReady[0] = 1'b0;
        setIn(0, 1'b1, a);
        @(negedge clk);
        checks++; if (occ[0] !== 2'd1) begin errors++; $display("[TB] FAIL full_occ1: got %0d expected 1", occ[0]); end
        checks++; if (inReady[0] !== 1'b1) begin errors++; $display("[TB] FAIL full_ready1: got %b expected 1", inReady[0]); end
        setIn(0, 1'b1, b);
        @(negedge clk);
        checks++; if (occ[0] !== 2'd2) begin errors++; $display("[TB] FAIL full_occ2: got %0d expected 2", occ[0]); end
        checks++; if (inReady[0] !== 1'b0) begin errors++; $display("[TB] FAIL full_ready2: got %b expected 0", inReady[0]); end
        checks++; if (outData[0] !== a.data) begin errors++; $display("[TB] FAIL full_headA: got %0h expected %0h", outData[0], a.data); end
        setIn(0, 1'b1, c);
        @(negedge clk);
        checks++; if (outCtrl[0] !== a.ctrl) begin errors++; $display("[TB] FAIL full_holdA: got %0h expected %0h", outCtrl[0], a.ctrl); end
        checks++; if (occ[0] !== 2'd2) begin errors++; $display("[TB] FAIL full_occ_hold: got %0d expected 2", occ[0]); end
        setIn(0, 1'b0, '0);
        outReady[0] = 1'b1;
        @(negedge clk);
        checks++; if (outData[0] !== b.data) begin errors++; $display("[TB] FAIL full_headB: got %0h expected %0h", outData[0], b.data); end
        checks++; if (outSrc[0] !== b.src) begin errors++; $display("[TB] FAIL full_srcB: got %0h expected %0h", outSrc[0], b.src); end
        checks++; if (inReady[0] !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_back: got %b expected 1", inReady[0]); end
        @(negedge clk);
        checks++; if (outValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL full_empty: got %b expected 0", outValid[0]); end
    endtask

    // Flush in the full state also kills the beat offered in that cycle
    task automatic test_flush_two();
        beat_t a, b;
        a = randBeat();
        b = randBeat();
        a.ctrl = 16'h1234;
        doReset();
        outReady[0] = 1'b0;
        setIn(0, 1'b1, a);
        @(negedge clk);
        setIn(0, 1'b1, b);
        @(negedge clk);
        checks++; if (occ[0] !== 2'd2) begin errors++; $display("[TB] FAIL flush_pre_occ: got %0d expected 2", occ[0]); end
        flush[0] = 1'b1;
        setIn(0, 1'b1, randBeat());
        @(negedge clk);
        checks++; if (outValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 0", outValid[0]); end
        checks++; if (outCtrl[0] !== '0) begin errors++; $display("[TB] FAIL flush_ctrl: got %0h expected 0", outCtrl[0]); end
        checks++; if (outSrc[0] !== '0) begin errors++; $display("[TB] FAIL flush_src: got %0h expected 0", outSrc[0]); end
        checks++; if (occ[0] !== 2'd0) begin errors++; $display("[TB] FAIL flush_occ: got %0d expected 0", occ[0]); end
        checks++; if (inReady[0] !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready: got %b expected 1", inReady[0]); end
        checks++; if (outData[0] !== a.data) begin errors++; $display("[TB] FAIL flush_keep_data: got %0h expected %0h", outData[0], a.data); end
        flush[0] = 1'b0;
        setIn(0, 1'b0, '0);
        outReady[0] = 1'b1;
        @(negedge clk);
        checks++; if (outValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL flush_ghost: got %b expected 0", outValid[0]); end
    endtask

    // Five backpressure cycles counted; a later flush leaves the count alone
    task automatic test_stall_count();
        beat_t a;
        a = randBeat();
        doReset();
        outReady[0] = 1'b0;
        setIn(0, 1'b1, a);
        @(negedge clk);
        setIn(0, 1'b0, '0);
        repeat (5) @(negedge clk);
        checks++; if (stall0 !== 16'd5) begin errors++; $display("[TB] FAIL stall_five: got %0d expected 5", stall0); end
        checks++; if (outData[0] !== a.data) begin errors++; $display("[TB] FAIL stall_stable: got %0h expected %0h", outData[0], a.data); end
        flush[0] = 1'b1;
        outReady[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0;
        checks++; if (stall0 !== 16'd5) begin errors++; $display("[TB] FAIL stall_after_flush: got %0d expected 5", stall0); end
        @(negedge clk);
        checks++; if (stall0 !== 16'd5) begin errors++; $display("[TB] FAIL stall_idle: got %0d expected 5", stall0); end
    endtask

    // Single-register stage: comb ready, 3-bit counter saturates at 7,
    // and X leaves on the same edge that Y is loaded
    task automatic test_noskid_saturate();
        beat_t x, y;
        x = randBeat();
        y = randBeat();
        doReset();
        outReady[1] = 1'b0;
        setIn(1, 1'b1, x);
        @(negedge clk);
        checks++; if (occ[1] !== 2'd1) begin errors++; $display("[TB] FAIL ns_occ: got %0d expected 1", occ[1]); end
        setIn(1, 1'b1, y);
        #1;
        checks++; if (inReady[1] !== 1'b0) begin errors++; $display("[TB] FAIL ns_ready_low: got %b expected 0", inReady[1]); end
        repeat (6) @(negedge clk);
        checks++; if (stall1 !== 3'd6) begin errors++; $display("[TB] FAIL ns_stall6: got %0d expected 6", stall1); end
        repeat (4) @(negedge clk);
        checks++; if (stall1 !== 3'd7) begin errors++; $display("[TB] FAIL ns_stall_sat: got %0d expected 7", stall1); end
        checks++; if (outData[1] !== x.data) begin errors++; $display("[TB] FAIL ns_holdX: got %0h expected %0h", outData[1], x.data); end
        outReady[1] = 1'b1;
        #1;
        checks++; if (inReady[1] !== 1'b1) begin errors++; $display("[TB] FAIL ns_ready_high: got %b expected 1", inReady[1]); end
        @(negedge clk);
        checks++; if (outData[1] !== y.data) begin errors++; $display("[TB] FAIL ns_loadY: got %0h expected %0h", outData[1], y.data); end
        checks++; if (outCtrl[1] !== y.ctrl) begin errors++; $display("[TB] FAIL ns_ctrlY: got %0h expected %0h", outCtrl[1], y.ctrl); end
        checks++; if (occ[1] !== 2'd1) begin errors++; $display("[TB] FAIL ns_occY: got %0d expected 1", occ[1]); end
        setIn(1, 1'b0, '0);
        @(negedge clk);
        checks++; if (outValid[1] !== 1'b0) begin errors++; $display("[TB] FAIL ns_drain: got %b expected 0", outValid[1]); end
    endtask

    // With CLR_DATA=1 a flush also clears the payload
    task automatic test_flush_clear();
        beat_t z;
        z = randBeat();
        z.data[0] = 1'b1;
        doReset();
        outReady[1] = 1'b0;
        setIn(1, 1'b1, z);
        @(negedge clk);
        checks++; if (outData[1] !== z.data) begin errors++; $display("[TB] FAIL clr_pre: got %0h expected %0h", outData[1], z.data); end
        flush[1] = 1'b1;
        setIn(1, 1'b1, randBeat());
        @(negedge clk);
        flush[1] = 1'b0;
        setIn(1, 1'b0, '0);
        checks++; if (outData[1] !== '0) begin errors++; $display("[TB] FAIL clr_data: got %0h expected 0", outData[1]); end
        checks++; if (outValid[1] !== 1'b0) begin errors++; $display("[TB] FAIL clr_valid: got %b expected 0", outValid[1]); end
    endtask

    // Random traffic on both instances against the FIFO model
    task automatic test_random();
        int    sz;
        logic  expV, expRdy;
        beat_t h, b;
        doReset();
        for (int cyc = 0; cyc < 2400; cyc++) begin
            for (int s = 0; s < 2; s++) begin
                sz     = qSize(s);
                expV   = (sz > 0);
                h      = expV ? qHead(s) : '0;
                expRdy = (s == 0) ? (sz < 2) : (sz == 0 || outReady[s] == 1'b1);
                checks++; if (outValid[s] !== expV) begin errors++; $display("[TB] FAIL rnd_valid%0d@%0d: got %b expected %b", s, cyc, outValid[s], expV); end
                checks++; if (occ[s] !== 2'(sz)) begin errors++; $display("[TB] FAIL rnd_occ%0d@%0d: got %0d expected %0d", s, cyc, occ[s], sz); end
                checks++; if (inReady[s] !== expRdy) begin errors++; $display("[TB] FAIL rnd_ready%0d@%0d: got %b expected %b", s, cyc, inReady[s], expRdy); end
                checks++; if (outCtrl[s] !== h.ctrl) begin errors++; $display("[TB] FAIL rnd_ctrl%0d@%0d: got %0h expected %0h", s, cyc, outCtrl[s], h.ctrl); end
                checks++; if (outSrc[s] !== h.src) begin errors++; $display("[TB] FAIL rnd_src%0d@%0d: got %0h expected %0h", s, cyc, outSrc[s], h.src); end
                if (expV) begin
                    checks++; if (outData[s] !== h.data) begin errors++; $display("[TB] FAIL rnd_data%0d@%0d: got %0h expected %0h", s, cyc, outData[s], h.data); end
                end
                checks++; if (getStall(s) !== 16'(mStall[s])) begin errors++; $display("[TB] FAIL rnd_stall%0d@%0d: got %0d expected %0d", s, cyc, getStall(s), mStall[s]); end

                // New stimulus; downstream readiness drifts from 25% to 100%
                b           = randBeat();
                flush[s]    = ($urandom_range(0, 19) == 0);
                outReady[s] = ($urandom_range(0, 3) <= ((cyc / 200) % 4));
                setIn(s, ($urandom_range(0, 3) != 0), b);

                // Model update for the coming edge
                expRdy = (s == 0) ? (sz < 2) : (sz == 0 || outReady[s] == 1'b1);
                if (sz > 0 && !outReady[s] && mStall[s] < stallMax(s)) mStall[s]++;
                if (flush[s]) begin
                    if (s == 0) q0.delete();
                    else q1.delete();
                end else begin
                    if (sz > 0 && outReady[s]) qPop(s);
                    if (inValid[s] && expRdy) qPush(s, b);
                end
            end
            @(negedge clk);
        end
        idleAll();
    endtask

    initial begin
        reset = 1'b1;
        idleAll();
        $display("[TB] start");
        test_reset();
        test_back_to_back();
        test_skid_full();
        test_flush_two();
        test_stall_count();
        test_noskid_saturate();
        test_flush_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
